// File: rtl/imem_responder_pkg.sv
// imem_responder_pkg: shared state encoding and constants for the instruction-memory responder
package imem_responder_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;
  localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/imem_responder_if.sv
// imem_responder_if: fetch request/response handshake between fetch stage and responder
interface imem_responder_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_inst;
  logic              rsp_err;
  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_inst, rsp_err
  );
  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_inst, rsp_err
  );
endinterface

// File: rtl/imem_word_array.sv
// imem_word_array: DEPTH x DATA_W store, one synchronous write port, one asynchronous read port
module imem_word_array #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/imem_responder.sv
// imem_responder: single-outstanding fetch responder with fixed wait states and a program-load port
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  imem_responder_if.slave   bus,
  input  logic              prog_we,
  input  logic [AW-1:0]     prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [15:0]       served_cnt
);
  state_e            state_q, state_d;
  logic              rdy_en_q, rdy_en_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] inst_q, inst_d, rd_data;
  logic              err_q, err_d;
  logic [15:0]       served_cnt_q, served_cnt_d;
  logic [ADDR_W-1:0] word_idx;
  logic              addr_err, accept, done;

  imem_word_array #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_mem (
    .clk   (clk),
    .we    (prog_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (word_idx[AW-1:0]),
    .rdata (rd_data)
  );

  assign word_idx       = bus.req_addr >> 2;
  assign addr_err       = |bus.req_addr[1:0] || word_idx >= ADDR_W'(DEPTH);
  assign accept         = bus.req_valid && bus.req_ready;
  assign done           = state_q == RESP && bus.rsp_ready;
  assign bus.req_ready  = state_q == IDLE && rdy_en_q;
  assign bus.rsp_valid  = state_q == RESP;
  assign bus.rsp_inst   = inst_q;
  assign bus.rsp_err    = err_q;
  assign served_cnt     = served_cnt_q;

  // Response word and error are frozen at accept so later program writes cannot disturb it.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    inst_d       = inst_q;
    err_d        = err_q;
    rdy_en_d     = 1'b1;
    served_cnt_d = served_cnt_q + 16'(done);
    if (accept) begin
      inst_d  = addr_err ? DATA_W'(NOP) : rd_data;
      err_d   = addr_err;
      cnt_d   = '0;
      state_d = WAIT_CYCLES == 0 ? RESP : WAIT;
    end
    if (state_q == WAIT) begin
      cnt_d   = cnt_q + 4'd1;
      state_d = cnt_q == 4'(WAIT_CYCLES - 1) ? RESP : WAIT;
    end
    if (done) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      rdy_en_q     <= 1'b0;
      cnt_q        <= '0;
      inst_q       <= '0;
      err_q        <= 1'b0;
      served_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      rdy_en_q     <= rdy_en_d;
      cnt_q        <= cnt_d;
      inst_q       <= inst_d;
      err_q        <= err_d;
      served_cnt_q <= served_cnt_d;
    end
  end
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: two responders (2 and 0 wait states) checked by a queue scoreboard against an array model
module tb_imem_responder;
  typedef struct {
    logic [31:0] inst;
    logic        err;
    int          cyc;
  } exp_t;
  localparam int WC [2] = '{2, 0};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid [2];
  logic [63:0] req_addr [2];
  logic        rsp_ready [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_inst [2];
  logic        rsp_err [2];
  logic [15:0] served [2];
  logic        prog_we = 1'b0;
  logic [5:0]  prog_addr = '0;
  logic [31:0] prog_data = '0;

  int          tests = 0, fails = 0, cyc = 0;
  exp_t        q [2][$];
  exp_t        cur [2];
  bit          busy [2];
  logic [15:0] exp_srv [2];
  logic [31:0] model [64];
  bit          rnd = 1'b0;

  always #5 clk = ~clk;

  imem_responder_if #(.ADDR_W(64), .DATA_W(32)) ia ();
  imem_responder_if #(.ADDR_W(64), .DATA_W(32)) ib ();

  assign ia.req_valid = req_valid[0];
  assign ia.req_addr  = req_addr[0];
  assign ia.rsp_ready = rsp_ready[0];
  assign req_ready[0] = ia.req_ready;
  assign rsp_valid[0] = ia.rsp_valid;
  assign rsp_inst[0]  = ia.rsp_inst;
  assign rsp_err[0]   = ia.rsp_err;
  assign ib.req_valid = req_valid[1];
  assign ib.req_addr  = req_addr[1];
  assign ib.rsp_ready = rsp_ready[1];
  assign req_ready[1] = ib.req_ready;
  assign rsp_valid[1] = ib.rsp_valid;
  assign rsp_inst[1]  = ib.rsp_inst;
  assign rsp_err[1]   = ib.rsp_err;

  imem_responder #(.ADDR_W(64), .DATA_W(32), .DEPTH(64), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .bus(ia.slave),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .served_cnt(served[0])
  );
  imem_responder #(.ADDR_W(64), .DATA_W(32), .DEPTH(64), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .bus(ib.slave),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .served_cnt(served[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference store: writes land on the edge, so a read taken before that edge sees the old word.
  always @(posedge clk) begin
    cyc++;
    if (prog_we) model[prog_addr] = prog_data;
  end

  always @(posedge clk) begin
    if (rnd) begin
      #1;
      if (rnd) begin
        rsp_ready[0] = $urandom_range(0, 3) != 0;
        rsp_ready[1] = $urandom_range(0, 3) != 0;
        prog_we      = $urandom_range(0, 3) == 0;
        prog_addr    = 6'($urandom_range(0, 63));
        prog_data    = $urandom;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : mon
    always @(negedge clk) begin
      if (!reset) begin
        q[g].delete();
        busy[g]    = 1'b0;
        exp_srv[g] = '0;
      end else begin
        chk("served_cnt", 32'(served[g]), 32'(exp_srv[g]));
        if (rsp_valid[g]) begin
          if (!busy[g]) begin
            chk("rsp_expected", 32'(q[g].size() != 0), 32'd1);
            if (q[g].size() != 0) begin
              cur[g]  = q[g].pop_front();
              busy[g] = 1'b1;
              chk("latency", 32'(cyc - cur[g].cyc), 32'(WC[g]));
            end
          end
          if (busy[g]) begin
            chk("rsp_inst", rsp_inst[g], cur[g].inst);
            chk("rsp_err", 32'(rsp_err[g]), 32'(cur[g].err));
          end
          if (rsp_ready[g]) begin
            busy[g] = 1'b0;
            exp_srv[g]++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input int s, input logic [63:0] addr, output int acc);
    bit          ok = 1'b0;
    int          n = 0;
    exp_t        e;
    logic [63:0] wi;
    req_valid[s] = 1'b1;
    req_addr[s]  = addr;
    acc          = -1;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = req_ready[s];
      n++;
    end
    chk("accept", 32'(ok), 32'd1);
    if (ok) begin
      wi     = addr >> 2;
      e.err  = addr[1:0] != 2'b00 || wi >= 64;
      e.inst = e.err ? 32'h0000_0013 : model[wi[5:0]];
      @(posedge clk);
      #1;
      e.cyc = cyc;
      acc   = cyc;
      q[s].push_back(e);
    end
    req_valid[s] = 1'b0;
  endtask

  task automatic wait_idle(input int s);
    int n = 0;
    while ((q[s].size() != 0 || busy[s] || rsp_valid[s]) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 32'(n < 300), 32'd1);
    tick();
  endtask

  function automatic logic [63:0] rand_addr();
    int r = $urandom_range(0, 9);
    if (r < 8) return 64'($urandom_range(0, 63)) << 2;
    if (r == 8) return (64'($urandom_range(0, 63)) << 2) | 64'($urandom_range(1, 3));
    return {32'($urandom), 32'($urandom)} | 64'h100;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected completion within time limit");
    $fatal(1);
  end

  initial begin
    int a, prev;
    logic [31:0] A [4];
    for (int i = 0; i < 4; i++) A[i] = 32'h00A0_0093 + 32'(i << 12);
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0;
      req_addr[s]  = '0;
      rsp_ready[s] = 1'b1;
    end
    // program load runs while reset is held: the store itself is not reset
    for (int i = 0; i < 64; i++) begin
      tick();
      prog_we   = 1'b1;
      prog_addr = 6'(i);
      prog_data = i < 4 ? A[i] : $urandom;
    end
    tick();
    prog_we = 1'b0;
    for (int s = 0; s < 2; s++) begin
      chk("rst_req_ready", 32'(req_ready[s]), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid[s]), 32'd0);
      chk("rst_rsp_inst", rsp_inst[s], 32'd0);
      chk("rst_rsp_err", 32'(rsp_err[s]), 32'd0);
      chk("rst_served", 32'(served[s]), 32'd0);
    end
    @(negedge clk);
    #1 reset = 1'b1;
    chk("ready_at_release", 32'(req_ready[0]), 32'd0);
    tick();
    chk("ready_after_release", 32'(req_ready[0]), 32'd1);

    // basic fetch of word 0
    fetch(0, 64'h0, a);
    wait_idle(0);
    chk("served_after_first", 32'(served[0]), 32'd1);

    // back-pressure: response held while rsp_ready is low
    rsp_ready[0] = 1'b0;
    fetch(0, 64'h4, a);
    for (int n = 0; n < 50 && !rsp_valid[0]; n++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("held_req_ready", 32'(req_ready[0]), 32'd0);
      chk("held_rsp_valid", 32'(rsp_valid[0]), 32'd1);
    end
    tick();
    rsp_ready[0] = 1'b1;
    tick();
    chk("post_hs_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("post_hs_req_ready", 32'(req_ready[0]), 32'd1);

    // misaligned and out-of-range addresses on both responders
    for (int s = 0; s < 2; s++) begin
      fetch(s, 64'h6, a);
      fetch(s, 64'h100, a);
      wait_idle(s);
    end

    // program write to word 1 in the accept cycle returns the old word
    prog_we   = 1'b1;
    prog_addr = 6'd1;
    prog_data = 32'hDEAD_BEEF;
    fetch(0, 64'h4, a);
    prog_we = 1'b0;
    fetch(0, 64'h4, a);
    wait_idle(0);
    chk("word1_updated", model[1], 32'hDEAD_BEEF);

    // reset while waiting drops the response and keeps the store
    fetch(0, 64'h0, a);
    reset = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("midrst_req_ready", 32'(req_ready[s]), 32'd0);
      chk("midrst_rsp_valid", 32'(rsp_valid[s]), 32'd0);
      chk("midrst_rsp_inst", rsp_inst[s], 32'd0);
      chk("midrst_rsp_err", 32'(rsp_err[s]), 32'd0);
      chk("midrst_served", 32'(served[s]), 32'd0);
    end
    req_valid[0] = 1'b1;
    req_addr[0]  = 64'h0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    chk("release_req_ready", 32'(req_ready[0]), 32'd0);
    tick();
    chk("no_accept_on_release", 32'(req_ready[0]), 32'd1);
    req_valid[0] = 1'b0;
    fetch(0, 64'h0, a);
    wait_idle(0);

    // zero wait states: one response every two cycles
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      fetch(1, 64'(i * 4), a);
      if (i > 0) chk("b2b_period", 32'(a - prev), 32'd2);
      prev = a;
    end
    wait_idle(1);
    force dut_b.served_cnt_q = 16'hFFFE;
    exp_srv[1] = 16'hFFFE;
    tick();
    release dut_b.served_cnt_q;
    for (int i = 0; i < 3; i++) fetch(1, 64'h8, a);
    wait_idle(1);
    chk("served_wrap", 32'(served[1]), 32'd1);

    // randomized traffic on both responders with random back-pressure and program writes
    rnd = 1'b1;
    fork
      begin
        int b;
        repeat (60) fetch(0, rand_addr(), b);
      end
      begin
        int b;
        repeat (60) fetch(1, rand_addr(), b);
      end
    join
    @(negedge clk);
    rnd          = 1'b0;
    rsp_ready[0] = 1'b1;
    rsp_ready[1] = 1'b1;
    prog_we      = 1'b0;
    wait_idle(0);
    wait_idle(1);
    chk("queue_empty_a", 32'(q[0].size()), 32'd0);
    chk("queue_empty_b", 32'(q[1].size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
